// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Control bundle ordering is {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam logic [3:0] OPC_LOAD = 4'b1010;
    localparam logic [3:0] OPC_NOP  = 4'b0000;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN      = 5'b11001;
    localparam ctrl_t CTRL_FREEZE   = 5'b00000;
    localparam ctrl_t CTRL_BRANCH   = 5'b11111;
    localparam ctrl_t CTRL_LOAD_USE = 5'b00011;
    localparam ctrl_t CTRL_FLUSH    = 5'b11101;
    localparam ctrl_t CTRL_RESET    = 5'b00110;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clear)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hold/flush/bubble sequencer for the 5-stage pipeline: load-use stalls,
// data-memory waits with timeout, and multi-cycle branch flush.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int                  OPCODE_W       = 4,
    parameter logic [OPCODE_W-1:0] LOAD_OPCODE    = OPCODE_W'(OPC_LOAD),
    parameter int                  BRANCH_PENALTY = 2,
    parameter int                  MEM_TIMEOUT    = 64,
    parameter int                  CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [OPCODE_W-1:0] ex_opcode,
    input  logic [OPCODE_W-1:0] mem_opcode,
    input  logic                branch_taken,
    input  logic                mem_req,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                if_id_flush,
    output logic                id_ex_bubble,
    output logic                pipe_en,
    output logic                stall_active,
    output logic                mem_timeout_err,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam logic [2:0] FLUSH_INIT = 3'(BRANCH_PENALTY - 1);
    localparam logic [7:0] TMO_MAX    = 8'(MEM_TIMEOUT);
    localparam state_e     BR_NEXT    = (BRANCH_PENALTY > 1) ? FLUSH : RUN;

    state_e     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       pend_br_q, pend_br_d;
    logic       tmo_err_q, tmo_err_d;

    ctrl_t ctrl;
    ctrl_t ctrl_out;
    logic  load_use;
    logic  mem_stall;
    logic  take_branch;

    // Kept on the port for the debug path; not part of the hazard decision.
    logic  unused_id_opcode;
    assign unused_id_opcode = ^id_opcode;

    assign load_use  = id_valid & ((ex_opcode == LOAD_OPCODE) | (mem_opcode == LOAD_OPCODE));
    assign mem_stall = mem_req & ~mem_ready;
    // A branch resolved in the same cycle the memory completes is honoured like a pending one.
    assign take_branch = pend_br_q | branch_taken;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        pend_br_d   = pend_br_q;
        tmo_err_d   = tmo_err_q;
        ctrl        = CTRL_RUN;

        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    ctrl      = CTRL_FREEZE;
                    state_d   = MEM_WAIT;
                    tmo_cnt_d = 8'd1;
                end else if (branch_taken) begin
                    ctrl        = CTRL_BRANCH;
                    state_d     = BR_NEXT;
                    flush_cnt_d = FLUSH_INIT;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end

            MEM_WAIT: begin
                if (mem_ready) begin
                    tmo_cnt_d = 8'd0;
                    pend_br_d = 1'b0;
                    if (take_branch) begin
                        ctrl        = CTRL_BRANCH;
                        state_d     = BR_NEXT;
                        flush_cnt_d = FLUSH_INIT;
                    end else if (flush_cnt_q != 3'd0) begin
                        // Resume a flush that was interrupted by the memory wait.
                        ctrl        = CTRL_FLUSH;
                        flush_cnt_d = flush_cnt_q - 3'd1;
                        state_d     = (flush_cnt_q == 3'd1) ? RUN : FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end else if (tmo_cnt_q == TMO_MAX) begin
                    tmo_err_d   = 1'b1;
                    state_d     = RUN;
                    pend_br_d   = 1'b0;
                    flush_cnt_d = 3'd0;
                    tmo_cnt_d   = 8'd0;
                end else begin
                    ctrl      = CTRL_FREEZE;
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (branch_taken)
                        pend_br_d = 1'b1;
                end
            end

            FLUSH: begin
                if (mem_stall) begin
                    ctrl      = CTRL_FREEZE;
                    state_d   = MEM_WAIT;
                    tmo_cnt_d = 8'd1;
                end else begin
                    ctrl = CTRL_FLUSH;
                    if (flush_cnt_q > 3'd1) begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end else begin
                        flush_cnt_d = 3'd0;
                        state_d     = RUN;
                    end
                end
            end

            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            tmo_cnt_q   <= 8'd0;
            pend_br_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            pend_br_q   <= pend_br_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    // Outputs are held safe while reset is asserted, independent of stored state.
    assign ctrl_out = rst_n ? ctrl : CTRL_RESET;

    assign pc_en           = ctrl_out.pc_en;
    assign if_id_en        = ctrl_out.if_id_en;
    assign if_id_flush     = ctrl_out.if_id_flush;
    assign id_ex_bubble    = ctrl_out.id_ex_bubble;
    assign pipe_en         = ctrl_out.pipe_en;
    assign stall_active    = rst_n & ~ctrl.pc_en;
    assign mem_timeout_err = tmo_err_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (~rst_n),
        .inc   (stall_active),
        .cnt_o (stall_cycles)
    );

endmodule
